// File: rtl/scaler_pkg.sv
// Shared types and constants for the scaled-stream timing regenerator.
// Raster geometry is fixed here; the mode helpers derive per-frame line length and active size.
package scaler_pkg;
  localparam int RGB_WIDTH  = 10;
  localparam int HACT       = 10;
  localparam int VACT       = 4;
  localparam int HTOTAL     = 14;
  localparam int OHSW       = 1;
  localparam int OHBP       = 2;
  localparam int OVSW       = 1;
  localparam int OVBP       = 0;
  localparam int FIFO_DEPTH = 16;
  localparam int VSYNC_POL  = 0;
  localparam int HSYNC_POL  = 0;

  localparam int HCNT_W = $clog2(3*HTOTAL);
  localparam int LCNT_W = $clog2(VACT+OVSW+OVBP+1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH)+1;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_HALF   = 2'b01,
    MODE_THIRD  = 2'b10
  } mode_e;

  typedef struct packed {
    logic [RGB_WIDTH-1:0] r;
    logic [RGB_WIDTH-1:0] g;
    logic [RGB_WIDTH-1:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBP, ST_WAIT_FILL, ST_ACTIVE, ST_VFP
  } regen_state_e;

  // Code 11 is unused by the scaler and falls back to bypass.
  function automatic mode_e decode_mode(logic [1:0] m);
    case (m)
      2'b01:   return MODE_HALF;
      2'b10:   return MODE_THIRD;
      default: return MODE_BYPASS;
    endcase
  endfunction

  function automatic logic [HCNT_W-1:0] line_len_of(mode_e m);
    case (m)
      MODE_HALF:  return HCNT_W'(2*HTOTAL);
      MODE_THIRD: return HCNT_W'(3*HTOTAL);
      default:    return HCNT_W'(HTOTAL);
    endcase
  endfunction

  function automatic logic [LVL_W-1:0] ohact_of(mode_e m);
    case (m)
      MODE_HALF:  return LVL_W'(HACT/2);
      MODE_THIRD: return LVL_W'(HACT/3);
      default:    return LVL_W'(HACT);
    endcase
  endfunction

  function automatic logic [LCNT_W-1:0] ovact_of(mode_e m);
    case (m)
      MODE_HALF:  return LCNT_W'(VACT/2);
      MODE_THIRD: return LCNT_W'(VACT/3);
      default:    return LCNT_W'(VACT);
    endcase
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock pixel FIFO with flush; a pop on a full FIFO frees room for a same-clock push.
module sync_fifo #(
  parameter int DATA_WIDTH = 30,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/scaled_timing_regen.sv
// Re-times a sparse DE-qualified scaled pixel stream into a regular raster whose line
// period is N input lines; a FIFO absorbs the burstiness between the two.
//
// state        | meaning
// ST_IDLE      | after reset, no frame seen; outputs quiet
// ST_VSYNC     | OVSW lines with vsync asserted
// ST_VBP       | OVBP blank lines (skipped when zero)
// ST_WAIT_FILL | blank lines until FIFO holds a full output line at a line boundary
// ST_ACTIVE    | OVACT lines with de window, one FIFO pop per de clock
// ST_VFP       | blank lines until the next input vsync edge
module scaled_timing_regen import scaler_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           i_mode,
  input  logic                 i_vsync,
  input  logic                 i_de,
  input  logic [RGB_WIDTH-1:0] i_r,
  input  logic [RGB_WIDTH-1:0] i_g,
  input  logic [RGB_WIDTH-1:0] i_b,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic                 o_de,
  output logic [RGB_WIDTH-1:0] o_r,
  output logic [RGB_WIDTH-1:0] o_g,
  output logic [RGB_WIDTH-1:0] o_b,
  output logic                 o_underflow,
  output logic                 o_overflow
);
  localparam logic [HCNT_W-1:0] DE_START = HCNT_W'(OHSW + OHBP);

  regen_state_e      state, state_nx;
  logic [HCNT_W-1:0] h_cnt, line_len;
  logic [LCNT_W-1:0] line_cnt, ovact;
  logic [LVL_W-1:0]  ohact, fifo_level;
  logic              vs_act, vs_d, frame_start, line_end;
  logic              fifo_full, fifo_empty, pop_eff;
  logic              hs_nx, vs_nx, de_nx;
  rgb_t              wr_pix, rd_pix;
  mode_e             mode;

  assign vs_act      = i_vsync ^ (VSYNC_POL != 0);
  assign frame_start = vs_act && !vs_d;
  assign line_end    = (h_cnt == line_len - HCNT_W'(1));
  assign mode        = decode_mode(i_mode);
  assign wr_pix      = '{r: i_r, g: i_g, b: i_b};
  assign pop_eff     = de_nx && !fifo_empty;

  sync_fifo #(.DATA_WIDTH(3*RGB_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (i_de),
    .pop     (de_nx),
    .flush   (frame_start),
    .wr_data (wr_pix),
    .rd_data (rd_pix),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // A vsync edge restarts the frame from any state, including mid-ACTIVE.
  always_comb begin
    state_nx = state;
    if (frame_start) state_nx = ST_VSYNC;
    else begin
      case (state)
        ST_VSYNC:     if (line_end && line_cnt == LCNT_W'(OVSW-1))
                        state_nx = (OVBP == 0) ? ST_WAIT_FILL : ST_VBP;
        ST_VBP:       if (line_end && line_cnt == LCNT_W'(OVBP-1)) state_nx = ST_WAIT_FILL;
        ST_WAIT_FILL: if (line_end && fifo_level >= ohact) state_nx = ST_ACTIVE;
        ST_ACTIVE:    if (line_end && line_cnt + LCNT_W'(1) == ovact) state_nx = ST_VFP;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d     <= 1'b0;
      h_cnt    <= '0;
      line_cnt <= '0;
      line_len <= '0;
      ohact    <= '0;
      ovact    <= '0;
    end else begin
      vs_d <= vs_act;
      if (frame_start) begin
        line_len <= line_len_of(mode);
        ohact    <= ohact_of(mode);
        ovact    <= ovact_of(mode);
        h_cnt    <= '0;
        line_cnt <= '0;
      end else if (state != ST_IDLE) begin
        h_cnt <= line_end ? '0 : h_cnt + HCNT_W'(1);
        if (line_end) line_cnt <= (state_nx != state) ? '0 : line_cnt + LCNT_W'(1);
      end
    end
  end

  always_comb begin
    hs_nx = 1'b0;
    vs_nx = (state == ST_VSYNC);
    de_nx = 1'b0;
    if (state != ST_IDLE) hs_nx = (h_cnt < HCNT_W'(OHSW));
    if (state == ST_ACTIVE)
      de_nx = (h_cnt >= DE_START) && (h_cnt < DE_START + HCNT_W'(ohact));
  end

  // Underflowing de clocks keep their slot in the raster but carry black.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vsync     <= (VSYNC_POL != 0);
      o_hsync     <= (HSYNC_POL != 0);
      o_de        <= 1'b0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_vsync     <= vs_nx ^ (VSYNC_POL != 0);
      o_hsync     <= hs_nx ^ (HSYNC_POL != 0);
      o_de        <= de_nx;
      o_r         <= pop_eff ? rd_pix.r : '0;
      o_g         <= pop_eff ? rd_pix.g : '0;
      o_b         <= pop_eff ? rd_pix.b : '0;
      o_underflow <= de_nx && fifo_empty;
      o_overflow  <= i_de && fifo_full && !pop_eff && !frame_start;
    end
  end
endmodule

// File: tb/tb_scaled_timing_regen.sv
// Directed bench for scaled_timing_regen: a frame-arithmetic model predicts every output
// cycle, and literal expectations pin first-de position, de counts and flag pulses.
module tb_scaled_timing_regen;
  import scaler_pkg::*;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [1:0]           i_mode = 2'b00;
  logic                 i_vsync = 1'b0, i_de = 1'b0;
  logic [RGB_WIDTH-1:0] i_r = '0, i_g = '0, i_b = '0;
  logic                 o_vsync, o_hsync, o_de, o_underflow, o_overflow;
  logic [RGB_WIDTH-1:0] o_r, o_g, o_b;

  always #5 clk = ~clk;

  scaled_timing_regen dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_vsync(i_vsync), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_underflow(o_underflow), .o_overflow(o_overflow)
  );

  int total = 0, bad = 0;
  int pid = 0;

  function automatic logic [29:0] pix(input int id);
    logic [9:0] r, g, b;
    r = 10'(id);
    g = 10'(id + 300);
    b = 10'(1000 - id);
    return {r, g, b};
  endfunction

  // Model: position in the frame is plain arithmetic on clocks since the vsync edge.
  logic [29:0] q[$];
  bit          fv = 0, vs_prev = 0, model_ok = 0;
  int          d, ll, ohact, ovact, first_act, nf;
  bit          ex_vs, ex_hs, ex_de, ex_uf, ex_of;
  logic [29:0] ex_rgb;

  initial forever begin
    bit start;
    int line, h;
    @(posedge clk);
    ex_vs = 0; ex_hs = 0; ex_de = 0; ex_uf = 0; ex_of = 0; ex_rgb = '0;
    if (rst) begin
      fv = 0; vs_prev = 0; q.delete();
    end else begin
      start = i_vsync && !vs_prev;
      vs_prev = i_vsync;
      if (fv) begin
        line = d / ll;
        h = d % ll;
        ex_vs = (line < OVSW);
        ex_hs = (h < OHSW);
        if (first_act < 0 && line >= OVSW + OVBP && h == ll - 1 && q.size() >= ohact)
          first_act = line + 1;
        ex_de = first_act >= 0 && line >= first_act && line < first_act + ovact
                && h >= OHSW + OHBP && h < OHSW + OHBP + ohact;
        d++;
      end
      if (ex_de) begin
        if (q.size() == 0) ex_uf = 1;
        else ex_rgb = q.pop_front();
      end
      if (start) begin
        nf = (i_mode == 2'b01) ? 2 : (i_mode == 2'b10) ? 3 : 1;
        ll = nf * HTOTAL; ohact = HACT / nf; ovact = VACT / nf;
        q.delete(); fv = 1; d = 0; first_act = -1;
      end else if (i_de) begin
        if (q.size() < FIFO_DEPTH) q.push_back({i_r, i_g, i_b});
        else ex_of = 1;
      end
    end
    model_ok = 1;
  end

  // Per-cycle compare plus monitor counters, sampled 2 units after the clock edge.
  int mc = 0, e_cyc = 0, de_cnt, uf_cnt, of_cnt, first_off, hs_last, hs_per;
  logic [29:0] first_data;
  bit hs_prev = 0;

  initial forever begin
    logic [34:0] act, exp_v;
    @(posedge clk);
    #2;
    mc++;
    if (model_ok) begin
      act   = {o_vsync, o_hsync, o_de, o_r, o_g, o_b, o_underflow, o_overflow};
      exp_v = {ex_vs, ex_hs, ex_de, ex_rgb, ex_uf, ex_of};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL cycle_outputs at clk %0d: got %h want %h (vs hs de rgb uf of)", mc, act, exp_v);
      end
    end
    if (o_de) begin
      de_cnt++;
      if (first_off < 0) begin first_off = mc - e_cyc; first_data = {o_r, o_g, o_b}; end
    end
    if (o_underflow) uf_cnt++;
    if (o_overflow) of_cnt++;
    if (o_hsync && !hs_prev) begin
      if (hs_last >= 0) hs_per = mc - hs_last;
      hs_last = mc;
    end
    hs_prev = o_hsync;
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_mon();
    de_cnt = 0; uf_cnt = 0; of_cnt = 0; first_off = -1; hs_last = -1; hs_per = 0;
    first_data = '0;
  endtask

  task automatic step(input bit de);
    @(negedge clk);
    i_vsync = 1'b0;
    i_de = de;
    if (de) begin {i_r, i_g, i_b} = pix(pid); pid++; end
    else {i_r, i_g, i_b} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic push_n(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic frame_start(input logic [1:0] m);
    @(negedge clk);
    i_mode = m; i_vsync = 1'b1; i_de = 1'b0; {i_r, i_g, i_b} = '0;
    clear_mon();
    e_cyc = mc + 1;
  endtask

  // Full-rate frame: one batch primes the FIFO, then one batch per active line after the first.
  task automatic run_full_rate(input logic [1:0] m, input string tag);
    int base;
    frame_start(m);
    base = pid;
    push_n(10); idle(4);
    idle(14);
    repeat (3) begin push_n(10); idle(4); end
    idle(14);
    idle(20);
    check({tag, "_first_de_offset"}, first_off, 32);
    check({tag, "_de_count"}, de_cnt, 40);
    check({tag, "_first_pixel"}, int'(first_data == pix(base)), 1);
    check({tag, "_underflows"}, uf_cnt, 0);
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs_zero",
          int'({o_vsync, o_hsync, o_de, o_r, o_g, o_b, o_underflow, o_overflow}), 0);

    // No frame yet: nothing pops, so the 17th push is dropped.
    clear_mon();
    push_n(17);
    idle(3);
    check("overflow_pulses", of_cnt, 1);
    check("idle_no_de", de_cnt, 0);

    run_full_rate(2'b00, "mode00");
    run_full_rate(2'b11, "mode11");

    // Half mode: 5 px spread over the vsync line, then only 4 px for the second active line.
    frame_start(2'b01);
    repeat (5) begin push_n(1); idle(4); end
    idle(3);
    idle(28);
    push_n(4); idle(24);
    idle(28);
    idle(40);
    check("mode01_first_de_offset", first_off, 60);
    check("mode01_de_count", de_cnt, 10);
    check("mode01_underflows", uf_cnt, 1);
    check("mode01_hsync_period", hs_per, 28);

    frame_start(2'b10);
    push_n(3);
    idle(42 * 4);
    check("mode10_first_de_offset", first_off, 88);
    check("mode10_de_count", de_cnt, 3);
    check("mode10_hsync_period", hs_per, 42);

    // Reset in the middle of the first active line.
    frame_start(2'b00);
    push_n(10); idle(4);
    idle(14);
    idle(6);
    @(negedge clk);
    rst = 1'b1; i_de = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_reset_outputs_zero",
          int'({o_vsync, o_hsync, o_de, o_r, o_g, o_b, o_underflow, o_overflow}), 0);
    clear_mon();
    idle(40);
    check("after_reset_no_de", de_cnt, 0);
    check("after_reset_no_hsync", hs_last, -1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
endmodule
